// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: latency limits and
// the in-flight read counter.
package fifo_rd_pkg;

  localparam int FIFO_RD_LAT_MIN = 1;
  localparam int FIFO_RD_LAT_MAX = 3;

  function automatic logic [1:0] popcount_lat(input logic [2:0] bits);
    return 2'(bits[0]) + 2'(bits[1]) + 2'(bits[2]);
  endfunction

endpackage

// File: rtl/fifo_rd_circ_buf.sv
// Small circular buffer with pointer wrap at an arbitrary depth; the head reads
// as zero while the buffer is empty.
module fifo_rd_circ_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH = 2,
  localparam int CNT_W = $clog2(BUF_DEPTH + 1),
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem_r [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(BUF_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // A push into a full buffer is only accepted when a pop frees a slot the same cycle.
  assign do_pop_s  = pop & (count_r != {CNT_W{1'b0}});
  assign do_push_s = push & ((count_r != CNT_W'(BUF_DEPTH)) | do_pop_s);

  // Storage write; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head of buffer, forced to zero when empty.
  always_comb begin
    dout = {DATA_WIDTH{1'b0}};
    if (count_r == {CNT_W{1'b0}}) begin
      dout = {DATA_WIDTH{1'b0}};
    end else begin
      dout = mem_r[rd_ptr_r];
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a standard-mode FIFO read port into a valid/ready stream, issuing reads
// only when buffer space is guaranteed for every word still in flight.
module fifo_rd_stream_adapter
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_READ_LATENCY = 1,
  localparam int BUF_DEPTH = FIFO_READ_LATENCY + 1,
  localparam int CNT_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  fifo_rd_rst_busy,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [CNT_W-1:0]      buf_count,
  output logic                  err_underflow
);

  localparam int PEND_W = CNT_W + 2;

  if ((FIFO_READ_LATENCY < FIFO_RD_LAT_MIN) || (FIFO_READ_LATENCY > FIFO_RD_LAT_MAX)) begin : g_bad_latency
    $error("fifo_rd_stream_adapter: FIFO_READ_LATENCY must be in 1..3");
  end

  logic [FIFO_READ_LATENCY-1:0] inflight_r;
  logic [2:0]                   inflight_ext_s;
  logic                         push_s;
  logic                         pop_s;
  logic [PEND_W-1:0]            pending_s;
  logic                         err_underflow_r;

  assign inflight_ext_s = 3'(inflight_r);
  assign push_s         = inflight_r[FIFO_READ_LATENCY-1];
  assign pop_s          = m_tvalid & m_tready;
  assign pending_s      = PEND_W'(buf_count) + PEND_W'(popcount_lat(inflight_ext_s));

  // Crediting the same-cycle pop keeps one word per clock under constant ready.
  assign fifo_rd_en = ~rst & ~fifo_empty & ~fifo_rd_rst_busy &
                      ((pending_s - PEND_W'(pop_s)) < PEND_W'(BUF_DEPTH));

  // In-flight read tracker; the MSB lines up with valid data on fifo_dout.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      inflight_r <= {FIFO_READ_LATENCY{1'b0}};
    end else begin
      inflight_r <= (inflight_r << 1) | FIFO_READ_LATENCY'(fifo_rd_en);
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      err_underflow_r <= 1'b0;
    end else if (fifo_underflow) begin
      err_underflow_r <= 1'b1;
    end else begin
      err_underflow_r <= err_underflow_r;
    end
  end

  fifo_rd_circ_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk  (rd_clk),
    .rst  (rst),
    .push (push_s),
    .pop  (pop_s),
    .din  (fifo_dout),
    .dout (m_tdata),
    .count(buf_count)
  );

  assign m_tvalid      = (buf_count != {CNT_W{1'b0}});
  assign err_underflow = err_underflow_r;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: two instances (read latency 1 and 3), each fed
// by a behavioural standard-mode FIFO, with a per-instance scoreboard of expected words.
module tb_fifo_rd_stream_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Instance with read latency 1 (buffer depth 2)
  logic [31:0] dout1 = 32'd0;
  logic        empty1, busy1 = 1'b0, uf_model1 = 1'b0, force_uf1 = 1'b0, uf1;
  logic        rd_en1, tvalid1, ready1 = 1'b0, err1;
  logic [31:0] tdata1;
  logic [1:0]  cnt1;

  // Instance with read latency 3 (buffer depth 4)
  logic [31:0] dout3, p0 = 32'd0, p1 = 32'd0, p2 = 32'd0;
  logic        empty3, busy3 = 1'b0, uf_model3 = 1'b0, uf3;
  logic        rd_en3, tvalid3, ready3 = 1'b0, err3;
  logic [31:0] tdata3;
  logic [2:0]  cnt3;

  logic [31:0] mem1 [2048];
  logic [31:0] mem3 [2048];
  int wptr1 = 0, rptr1 = 0, wptr3 = 0, rptr3 = 0;

  logic [31:0] sb1 [$];
  logic [31:0] sb3 [$];
  int checks = 0, errors = 0, rd_pulses1 = 0, sent = 0;

  assign empty1 = (rptr1 == wptr1);
  assign empty3 = (rptr3 == wptr3);
  assign uf1    = uf_model1 | force_uf1;
  assign uf3    = uf_model3;
  assign dout3  = p2;

  // Behavioural FIFO, read latency 1
  always @(posedge clk) begin
    if (rd_en1 && !empty1) begin
      dout1 <= mem1[rptr1 % 2048];
      rptr1 <= rptr1 + 1;
    end
    uf_model1 <= rd_en1 && empty1;
  end

  // Behavioural FIFO, read latency 3
  always @(posedge clk) begin
    if (rd_en3 && !empty3) begin
      p0    <= mem3[rptr3 % 2048];
      rptr3 <= rptr3 + 1;
    end
    p1 <= p0;
    p2 <= p1;
    uf_model3 <= rd_en3 && empty3;
  end

  fifo_rd_stream_adapter #(.DATA_WIDTH(32), .FIFO_READ_LATENCY(1)) u_dut1 (
    .rd_clk(clk), .rst(rst), .fifo_dout(dout1), .fifo_empty(empty1),
    .fifo_rd_rst_busy(busy1), .fifo_underflow(uf1), .fifo_rd_en(rd_en1),
    .m_tdata(tdata1), .m_tvalid(tvalid1), .m_tready(ready1),
    .buf_count(cnt1), .err_underflow(err1)
  );

  fifo_rd_stream_adapter #(.DATA_WIDTH(32), .FIFO_READ_LATENCY(3)) u_dut3 (
    .rd_clk(clk), .rst(rst), .fifo_dout(dout3), .fifo_empty(empty3),
    .fifo_rd_rst_busy(busy3), .fifo_underflow(uf3), .fifo_rd_en(rd_en3),
    .m_tdata(tdata3), .m_tvalid(tvalid3), .m_tready(ready3),
    .buf_count(cnt3), .err_underflow(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [31:0] d);
    mem1[wptr1 % 2048] = d;
    wptr1++;
    sb1.push_back(d);
  endtask

  task automatic push3(input logic [31:0] d);
    mem3[wptr3 % 2048] = d;
    wptr3++;
    sb3.push_back(d);
  endtask

  // Sample just before the rising edge, score any transfer, then move to the next negedge.
  task automatic cyc();
    logic [31:0] exp_w;
    #2;
    if (rd_en1) rd_pulses1++;
    if (!rst) begin
      if (tvalid1 && ready1) begin
        checks++;
        assert (sb1.size() != 0) else begin
          errors++;
          $error("FAIL sb1_extra observed=%0h expected=none", tdata1);
        end
        if (sb1.size() != 0) begin
          exp_w = sb1.pop_front();
          chk("sb1_data", tdata1, exp_w);
        end
      end
      if (tvalid3 && ready3) begin
        checks++;
        assert (sb3.size() != 0) else begin
          errors++;
          $error("FAIL sb3_extra observed=%0h expected=none", tdata3);
        end
        if (sb3.size() != 0) begin
          exp_w = sb3.pop_front();
          chk("sb3_data", tdata3, exp_w);
        end
      end
      chk("buf_bound3", 32'(cnt3 <= 3'd4), 32'd1);
      chk("err3_clear", 32'(err3), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset with a word already waiting in FIFO1: no read may be issued during reset
    rst = 1'b1;
    push1(32'h1);
    cyc();
    cyc();
    chk("rst_rd_en1", 32'(rd_en1), 32'd0);
    chk("rst_tvalid1", 32'(tvalid1), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_err1", 32'(err1), 32'd0);
    chk("rst_tdata1", tdata1, 32'd0);
    chk("rst_rd_en3", 32'(rd_en3), 32'd0);
    chk("rst_tvalid3", 32'(tvalid3), 32'd0);
    chk("rst_cnt3", 32'(cnt3), 32'd0);
    chk("rst_tdata3", tdata3, 32'd0);

    // Streaming at latency 1 with constant ready: 8 words on consecutive cycles
    rst = 1'b0;
    ready1 = 1'b1;
    for (int i = 2; i <= 8; i++) push1(32'(i));
    rd_pulses1 = 0;
    #1;
    chk("first_rd_en1", 32'(rd_en1), 32'd1);
    cyc();
    chk("lat_tvalid_lo", 32'(tvalid1), 32'd0);
    cyc();
    for (int i = 1; i <= 8; i++) begin
      chk("stream_tvalid1", 32'(tvalid1), 32'd1);
      chk("stream_tdata1", tdata1, 32'(i));
      cyc();
    end
    chk("stream_cnt1_end", 32'(cnt1), 32'd0);
    chk("stream_tvalid1_end", 32'(tvalid1), 32'd0);
    chk("stream_rd_pulses", 32'(rd_pulses1), 32'd8);
    chk("stream_sb1_empty", 32'(sb1.size()), 32'd0);

    // Backpressure: 16 words, stalled for 20 cycles
    ready1 = 1'b0;
    for (int i = 0; i < 16; i++) push1(32'h100 + 32'(i));
    rd_pulses1 = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i >= 1) begin
        chk("stall_tvalid1", 32'(tvalid1), 32'd1);
        chk("stall_tdata1", tdata1, 32'h100);
      end
    end
    chk("stall_rd_pulses", 32'(rd_pulses1), 32'd2);
    chk("stall_cnt1", 32'(cnt1), 32'd2);
    ready1 = 1'b1;
    #1;
    chk("reassert_rd_en1", 32'(rd_en1), 32'd1);
    for (int i = 0; i < 40 && sb1.size() != 0; i++) cyc();
    chk("stall_drain", 32'(sb1.size()), 32'd0);
    chk("stall_total_rd", 32'(rd_pulses1), 32'd16);
    chk("stall_cnt1_end", 32'(cnt1), 32'd0);

    // Empty FIFO, then read-domain reset busy with data waiting
    rd_pulses1 = 0;
    for (int i = 0; i < 10; i++) cyc();
    chk("empty_no_rd", 32'(rd_pulses1), 32'd0);
    busy1 = 1'b1;
    for (int i = 0; i < 3; i++) push1(32'h200 + 32'(i));
    for (int i = 0; i < 10; i++) cyc();
    chk("busy_no_rd", 32'(rd_pulses1), 32'd0);
    chk("busy_tvalid1", 32'(tvalid1), 32'd0);
    busy1 = 1'b0;
    #1;
    chk("busy_clear_rd_en", 32'(rd_en1), 32'd1);
    for (int i = 0; i < 20 && sb1.size() != 0; i++) cyc();
    chk("busy_drain", 32'(sb1.size()), 32'd0);
    chk("busy_total_rd", 32'(rd_pulses1), 32'd3);

    // Latency 3, random ready and bursty writes, 1000 words
    sent = 0;
    for (int i = 0; i < 8000 && (sent < 1000 || sb3.size() != 0); i++) begin
      if (sent < 1000 && $urandom_range(0, 1) == 1) begin
        push3($urandom);
        sent++;
      end
      ready3 = ($urandom_range(0, 1) == 1);
      cyc();
    end
    chk("rand_drain", 32'(sb3.size()), 32'd0);
    chk("rand_sent", 32'(sent), 32'd1000);

    // Reset with one word buffered and two reads in flight
    ready3 = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    push3(32'hA1);
    push3(32'hA2);
    push3(32'hA3);
    for (int i = 0; i < 4; i++) cyc();
    chk("pre_rst_cnt3", 32'(cnt3), 32'd1);
    chk("pre_rst_tdata3", tdata3, 32'hA1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("post_rst_tvalid3", 32'(tvalid3), 32'd0);
    chk("post_rst_cnt3", 32'(cnt3), 32'd0);
    sb3.delete();
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("discard_cnt3", 32'(cnt3), 32'd0);
    end
    for (int i = 0; i < 4; i++) push3(32'hB1 + 32'(i));
    ready3 = 1'b1;
    for (int i = 0; i < 30 && sb3.size() != 0; i++) cyc();
    chk("post_rst_drain", 32'(sb3.size()), 32'd0);

    // Sticky underflow flag
    chk("uf_pre", 32'(err1), 32'd0);
    force_uf1 = 1'b1;
    cyc();
    force_uf1 = 1'b0;
    chk("uf_set", 32'(err1), 32'd1);
    for (int i = 0; i < 5; i++) cyc();
    chk("uf_sticky", 32'(err1), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("uf_cleared", 32'(err1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream_adapter.md
# fifo_rd_stream_adapter

Read-side drain engine for the standard-mode (non-FWFT) FIFO read port in the read clock domain. It issues `rd_en` to the FIFO, tracks reads still in flight through the FIFO read latency, and captures returning words in a small local buffer. It presents them on a valid/ready stream master. It delivers one word per clock when the consumer is always ready, and it never over-reads or drops a word under backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of the FIFO `dout` and of `m_tdata`.
- `FIFO_READ_LATENCY`, 1, cycles from `fifo_rd_en` to valid `fifo_dout`. Legal values are 1..3; any other value is an elaboration error.
- `BUF_DEPTH` (localparam), `FIFO_READ_LATENCY+1`, local buffer entries.

Ports:
- `rd_clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `fifo_dout` input `DATA_WIDTH`: FIFO read data.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_rd_rst_busy` input 1: FIFO read-domain reset in progress.
- `fifo_underflow` input 1: FIFO underflow flag.
- `fifo_rd_en` output 1: FIFO read enable.
- `m_tdata` output `DATA_WIDTH`: stream data.
- `m_tvalid` output 1: stream valid.
- `m_tready` input 1: stream ready.
- `buf_count` output `$clog2(BUF_DEPTH+1)`: number of words held in the local buffer.
- `err_underflow` output 1: sticky underflow indication.

## Operation
- `inflight` is a `FIFO_READ_LATENCY`-bit shift register of issued reads. Bit 0 is loaded with `fifo_rd_en`; the MSB marks a word present on `fifo_dout` this cycle.
- The buffer write strobe `push` = `inflight` MSB. A push captures `fifo_dout` at the tail.
- `pop` = `m_tvalid & m_tready`.
- `pending` = `buf_count` + popcount(`inflight`).
- `fifo_rd_en` = `!rst & !fifo_empty & !fifo_rd_rst_busy & (pending - pop < BUF_DEPTH)`. It is combinational, so the FIFO is never read during reset and the buffer can never overflow.
- The buffer is a circular FIFO of `BUF_DEPTH` entries.
  - Read and write pointers wrap at `BUF_DEPTH`, which need not be a power of two: an index at `BUF_DEPTH-1` goes to 0.
  - A simultaneous `push` and `pop` leaves `buf_count` unchanged and advances both pointers.
- `m_tvalid` = (`buf_count != 0`). `m_tdata` = the head entry, held stable while `m_tvalid & !m_tready`.
- `err_underflow` sets on any cycle with `fifo_underflow` = 1 and clears only on `rst`. This is a design-error flag: correct gating never underflows.
- `rst` mid-operation clears the buffer, pointers and `inflight`. Words in flight are discarded and are not re-read.

## Timing
- Reset values are: `fifo_rd_en` 0, `m_tvalid` 0, `buf_count` 0, `err_underflow` 0, `m_tdata` 0. Buffer storage is not reset; `m_tdata` reads 0 because the head is forced to 0 while `buf_count` = 0.
- If `fifo_empty` is 0 and the buffer is empty in cycle t, then `fifo_rd_en` = 1 in cycle t.
  - The word is captured at the end of cycle t+`FIFO_READ_LATENCY`.
  - `m_tvalid` = 1 in cycle t+`FIFO_READ_LATENCY`+1.
- Steady state with `m_tready` held 1 and the FIFO non-empty: `fifo_rd_en` and `m_tvalid` stay 1 every cycle, giving 1 word/clk.
- With `m_tready` = 0, `fifo_rd_en` drops once `pending` = `BUF_DEPTH`. At most `BUF_DEPTH` words are ever buffered.
- When `m_tready` rises, the first pop happens the same cycle. `fifo_rd_en` reasserts the same cycle through the `-pop` term.
- `fifo_rd_rst_busy` = 1 blocks new reads. Reads already in flight still complete and are buffered.

## Structure
- Package `fifo_rd_pkg` holds:
  - the function `popcount_lat(logic [2:0])`;
  - the latency range limits `FIFO_RD_LAT_MIN` = 1 and `FIFO_RD_LAT_MAX` = 3.
- Sub-module `fifo_rd_circ_buf`, parameterised by `DATA_WIDTH` and `BUF_DEPTH`, holds the circular buffer: `push`/`pop`/`din`/`dout`/`count` with non-power-of-two wrap. The top level contains only the credit logic and `inflight`.

## Test plan
- Reset, then preload 8 words 0x1..0x8 with `m_tready` = 1 and `FIFO_READ_LATENCY` = 1 → `m_tvalid` first rises 2 cycles after `rd_en`, words 0x1..0x8 appear on 8 consecutive cycles, `buf_count` returns to 0, 8 `rd_en` pulses in total.
- Preload 16 words, `m_tready` = 0 for 20 cycles, then 1 → exactly `BUF_DEPTH` `rd_en` pulses during the stall, `buf_count` = `BUF_DEPTH`, `m_tdata` stable at word 0, all 16 words delivered in order with none lost.
- `FIFO_READ_LATENCY` = 3, `m_tready` toggled randomly for 1000 words → output sequence matches input, `buf_count` ≤ 4 always, `err_underflow` stays 0.
- FIFO empty → `rd_en` never asserts. `fifo_rd_rst_busy` = 1 with FIFO non-empty → `rd_en` stays 0 until busy clears.
- Pulse `rst` while 2 reads are in flight and `buf_count` = 1 → next cycle `m_tvalid` 0, `buf_count` 0; the discarded words never appear; the next words stream correctly.
- Force `fifo_underflow` = 1 for one cycle → `err_underflow` = 1 from the next cycle until `rst`.
